// File: rtl/gp_irq_dispatcher.sv
// gp_irq_dispatcher: gates controller IRQs with the core enable, offers a handler address and tracks service
module gp_irq_dispatcher #(
  parameter int ADDR_W = 32,
  parameter int VEC_W = 5,
  parameter int ENTRY_SHIFT = 2,
  parameter logic [ADDR_W-1:0] VTOR_RESET = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              irq_req,
  input  logic [VEC_W-1:0]  irq_vector,
  output logic              irq_ack,
  input  logic              core_int_en,
  output logic              core_irq_valid,
  output logic [ADDR_W-1:0] core_irq_addr,
  input  logic              core_irq_ready,
  input  logic              core_irq_ret,
  output logic              in_service,
  input  logic              reg_en,
  input  logic              reg_we,
  input  logic [3:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata
);
  localparam int LOW = VEC_W + ENTRY_SHIFT;
  localparam logic [ADDR_W-1:0] MASK = {{(ADDR_W-LOW){1'b1}}, {LOW{1'b0}}};
  typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;
  state_t state, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0] vtor;
  logic [31:0] count, rd_d;
  logic err, accept, wr, go;
  assign go = irq_req && core_int_en;
  assign core_irq_valid = state == OFFER && go && irq_vector == vec_q;
  assign accept = core_irq_valid && core_irq_ready;
  assign irq_ack = accept;
  assign in_service = state == SERVICE;
  assign core_irq_addr = vtor | ADDR_W'({vec_q, ENTRY_SHIFT'(0)});
  assign wr = reg_en && reg_we;
  // next state and captured vector; a vector change during OFFER re-arms the offer
  always_comb begin
    state_d = state;
    vec_d = vec_q;
    if (state == IDLE && go) begin
      state_d = OFFER;
      vec_d = irq_vector;
    end else if (state == OFFER) begin
      state_d = accept ? SERVICE : !go ? IDLE : OFFER;
      vec_d = (!accept && go) ? irq_vector : vec_q;
    end else if (state == SERVICE && core_irq_ret)
      state_d = IDLE;
  end
  // read mux for the register window
  always_comb begin
    rd_d = reg_addr == 4'd0 ? 32'(vtor) :
           reg_addr == 4'd1 ? 32'({err, in_service, state, vec_q}) :
           reg_addr == 4'd2 ? count : 32'd0;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      vec_q <= '0;
    end else begin
      state <= state_d;
      vec_q <= vec_d;
    end
  end
  // register window, dispatch counter and sticky RETI error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vtor <= VTOR_RESET & MASK;
      count <= '0;
      err <= 1'b0;
      reg_rdata <= '0;
    end else begin
      if (wr && reg_addr == 4'd0) vtor <= reg_wdata[ADDR_W-1:0] & MASK;
      if (wr && reg_addr == 4'd2) count <= '0;
      else if (accept) count <= count + 32'd1;
      if (core_irq_ret && state != SERVICE) err <= 1'b1;
      else if (wr && reg_addr == 4'd1 && reg_wdata[8]) err <= 1'b0;
      if (reg_en && !reg_we) reg_rdata <= rd_d;
    end
  end
endmodule
